data_mem_ctrl: RTL and testbench

Multi-cycle load/store sequencer between the core's execute stage and a single-port 32-bit word-addressed data memory with a req/ack handshake. It accepts one load or store command (LB/LH/LW/LBU/LHU/SB/SH/SW), checks alignment, and issues the memory transactions. Sub-word stores use a read-modify-write sequence because the memory has no byte enables. It returns the extended load data and holds the pipeline stalled while busy.

---
 rtl/data_mem_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Multi-cycle load/store sequencer between the execute stage and a
//            single-port, word-addressed 32-bit data memory (req/ack). Checks
//            alignment/legality, performs read-modify-write for SB/SH (the
//            memory has no byte enables), extends load data, and stalls the
//            pipeline while busy.
// Ports    : clk_i/rst_i        clock, async active-high reset
//            start_i            command valid (sampled in IDLE only)
//            load_i/store_i     command kind
//            funct3_i           RV32I load/store funct3
//            addr_i/wdata_i     byte address, store data
//            busy_o/done_o      stall, one-cycle completion pulse
//            err_o/rdata_o      error flag and load result (valid with done_o)
//            mem_*              memory request interface
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_READ  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic [2:0]        r_funct3;
  logic              r_load;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic              w_illegal;
  logic              w_misalign;
  logic              w_timeout;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;
  logic [31:0]       w_merge;

  // Command decode, only meaningful in IDLE with start_i high.
  assign w_illegal = (load_i == store_i)
                   | (load_i  & ((funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11)))
                   | (store_i & (funct3_i[2] | (funct3_i[1:0] == 2'b11)));

  assign w_misalign = ((funct3_i[1:0] == 2'b01) & addr_i[0])
                    | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));

  // Last permitted wait cycle; an ack in this same cycle still wins.
  assign w_timeout = (r_cnt == c_TO_LAST);

  // Lane selection from the captured word.
  always_comb begin
    w_byte = r_data[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = r_data[7:0];
      2'd1:    w_byte = r_data[15:8];
      2'd2:    w_byte = r_data[23:16];
      default: w_byte = r_data[31:24];
    endcase
  end

  assign w_half = r_addr[1] ? r_data[31:16] : r_data[15:0];

  always_comb begin
    w_load_ext = r_data;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = r_data;
    endcase
  end

  // Store word: sub-word stores patch the lane into the word read back first.
  always_comb begin
    w_merge = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_merge = r_data;
        case (r_addr[1:0])
          2'd0:    w_merge[7:0]   = r_wdata[7:0];
          2'd1:    w_merge[15:8]  = r_wdata[7:0];
          2'd2:    w_merge[23:16] = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        w_merge = r_data;
        if (r_addr[1]) begin
          w_merge[31:16] = r_wdata[15:0];
        end else begin
          w_merge[15:0]  = r_wdata[15:0];
        end
      end
      default: w_merge = r_wdata;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= c_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_data   <= '0;
      r_funct3 <= '0;
      r_load   <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start_i) begin
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            r_funct3 <= funct3_i;
            r_load   <= load_i;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            if (w_illegal || w_misalign) begin
              r_err   <= 1'b1;
              r_state <= c_RESP;
            end else if (load_i || (funct3_i[1:0] != 2'b10)) begin
              // Loads and SB/SH both start by reading the word.
              r_state <= c_READ;
            end else begin
              r_state <= c_WRITE;
            end
          end
        end
        c_READ: begin
          if (mem_ack_i) begin
            r_data  <= mem_rdata_i;
            r_cnt   <= '0;
            r_state <= r_load ? c_RESP : c_WRITE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= c_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_WRITE: begin
          if (mem_ack_i) begin
            r_state <= c_RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= c_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // All outputs decode directly from state so reset clears them immediately.
  assign busy_o      = (r_state != c_IDLE);
  assign done_o      = (r_state == c_RESP);
  assign err_o       = done_o & r_err;
  assign rdata_o     = (done_o && !r_err && r_load) ? w_load_ext : 32'd0;
  assign mem_req_o   = (r_state == c_READ) || (r_state == c_WRITE);
  assign mem_we_o    = (r_state == c_WRITE);
  assign mem_addr_o  = mem_req_o ? r_addr[ADDR_W-1:2] : '0;
  assign mem_wdata_o = mem_we_o ? w_merge : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Directed, table-driven bench for data_mem_ctrl with a small
//            word memory model whose ack delay is selectable per command
//            (-1 means the memory never acknowledges).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        load_i = 1'b0;
  logic        store_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        mem_ack_i = 1'b0;

  data_mem_ctrl #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .load_i(load_i),
    .store_i(store_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  int          delay = 0;
  int          wait_cnt = 0;
  int          req_cnt = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wword = 32'd0;

  always @(negedge clk_i) begin
    mem_rdata_i = mem[mem_addr_o[9:0]];
    mem_ack_i   = mem_req_o && (delay >= 0) && (wait_cnt == delay);
    if (mem_req_o) req_cnt++;
    if (done_o) done_cnt++;
  end

  always @(posedge clk_i) begin
    if (mem_req_o && !mem_ack_i) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
    if (mem_req_o && mem_we_o && mem_ack_i) begin
      mem[mem_addr_o[9:0]] <= mem_wdata_o;
      wr_cnt     <= wr_cnt + 1;
      last_wword <= mem_wdata_o;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one command in the next cycle and waits for done_o.
  // inj > 0 pulses a second (LW) start at that cycle while busy.
  task automatic run_cmd(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int dly, input int inj,
                         output int lat, output logic e, output logic [31:0] rd);
    int busy_bad;
    busy_bad = 0;
    lat = 0;
    e = 1'b0;
    rd = 32'd0;
    @(negedge clk_i);
    chk("idle_before_start", {31'd0, busy_o}, 32'd0);
    delay = dly;
    start_i = 1'b1; load_i = ld; store_i = st; funct3_i = f3;
    addr_i = a; wdata_i = wd;
    @(posedge clk_i);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (c == inj) begin
        start_i = 1'b1; load_i = 1'b1; store_i = 1'b0;
        funct3_i = 3'b010; addr_i = 32'h20;
      end else begin
        start_i = 1'b0;
      end
      if (!busy_o) busy_bad++;
      if (done_o) begin
        lat = c; e = err_o; rd = rdata_o;
        break;
      end
    end
    start_i = 1'b0;
    chk("busy_while_active", busy_bad, 0);
  endtask

  typedef struct {
    string       name;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, init;
    int          dly, lat;
    logic        err;
    logic [31:0] rdata;
    int          reqs, wrs;
    logic [31:0] wword;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          lat, r0, d0, w0;
    logic        e;
    logic [31:0] rd;

    for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;

    //         name    ld    st    f3      addr          wdata         init          dly lat err rdata          reqs wrs wword
    vecs.push_back('{"LB3",  1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 2, 1'b0, 32'hFFFF_FF80, 1, 0, 32'h0});
    vecs.push_back('{"LBU3", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 2, 1'b0, 32'h0000_0080, 1, 0, 32'h0});
    vecs.push_back('{"LB1",  1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h80FF_1234, 1, 3, 1'b0, 32'h0000_0012, 2, 0, 32'h0});
    vecs.push_back('{"LH2",  1'b1, 1'b0, 3'b001, 32'h0000_0042, 32'h0,        32'h8001_7FFF, 0, 2, 1'b0, 32'hFFFF_8001, 1, 0, 32'h0});
    vecs.push_back('{"LHU2", 1'b1, 1'b0, 3'b101, 32'h0000_0042, 32'h0,        32'h8001_7FFF, 0, 2, 1'b0, 32'h0000_8001, 1, 0, 32'h0});
    vecs.push_back('{"LH0",  1'b1, 1'b0, 3'b001, 32'h0000_0040, 32'h0,        32'h8001_7FFF, 0, 2, 1'b0, 32'h0000_7FFF, 1, 0, 32'h0});
    vecs.push_back('{"LW",   1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0,        32'h1234_5678, 0, 2, 1'b0, 32'h1234_5678, 1, 0, 32'h0});
    vecs.push_back('{"SH",   1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_5678, 32'h1111_2222, 3, 9, 1'b0, 32'h0,         8, 1, 32'h5678_2222});
    vecs.push_back('{"SB3",  1'b0, 1'b1, 3'b000, 32'h0000_0303, 32'h1234_56EF, 32'h1122_3344, 1, 5, 1'b0, 32'h0,         4, 1, 32'hEF22_3344});
    vecs.push_back('{"SW",   1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        0, 2, 1'b0, 32'h0,         1, 1, 32'hCAFE_F00D});
    vecs.push_back('{"LWmis",1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,         0, 0, 32'h0});
    vecs.push_back('{"SHmis",1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,         0, 0, 32'h0});
    vecs.push_back('{"SWmis",1'b0, 1'b1, 3'b010, 32'h0000_0012, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,         0, 0, 32'h0});
    vecs.push_back('{"LDST", 1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,         0, 0, 32'h0});
    vecs.push_back('{"NONE", 1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,         0, 0, 32'h0});
    vecs.push_back('{"L011", 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,         0, 0, 32'h0});
    vecs.push_back('{"L110", 1'b1, 1'b0, 3'b110, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,         0, 0, 32'h0});
    vecs.push_back('{"S100", 1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,         0, 0, 32'h0});

    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_req",  {31'd0, mem_req_o}, 32'd0);
    chk("rst_outs", rdata_o | mem_wdata_o | {2'd0, mem_addr_o} | {31'd0, err_o | mem_we_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      mem[vecs[i].addr[11:2]] <= vecs[i].init;
      r0 = req_cnt; d0 = done_cnt; w0 = wr_cnt;
      run_cmd(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              vecs[i].dly, 0, lat, e, rd);
      @(negedge clk_i);
      chk({vecs[i].name, "_lat"},   lat, vecs[i].lat);
      chk({vecs[i].name, "_err"},   {31'd0, e}, {31'd0, vecs[i].err});
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
      chk({vecs[i].name, "_reqs"},  req_cnt - r0, vecs[i].reqs);
      chk({vecs[i].name, "_dones"}, done_cnt - d0, 1);
      chk({vecs[i].name, "_wrs"},   wr_cnt - w0, vecs[i].wrs);
      if (vecs[i].wrs != 0) chk({vecs[i].name, "_wword"}, last_wword, vecs[i].wword);
    end

    // SW timeout with a second start pulsed while busy
    r0 = req_cnt; d0 = done_cnt; w0 = wr_cnt;
    run_cmd(1'b0, 1'b1, 3'b010, 32'h10, 32'h5555_AAAA, -1, 5, lat, e, rd);
    chk("to_lat",  lat, 17);
    chk("to_err",  {31'd0, e}, 32'd1);
    chk("to_rdata", rd, 32'd0);
    chk("to_reqs", req_cnt - r0, 16);
    repeat (5) @(negedge clk_i);
    chk("to_idle_after", {31'd0, busy_o}, 32'd0);
    chk("to_dones", done_cnt - d0, 1);
    chk("to_no_extra_req", req_cnt - r0, 16);
    chk("to_wrs", wr_cnt - w0, 0);

    // Asynchronous reset in the middle of a READ
    d0 = done_cnt;
    delay = -1;
    @(negedge clk_i);
    start_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h20;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_req_before", {31'd0, mem_req_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    mem[8] <= 32'hDEAD_BEEF;
    run_cmd(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, 0, lat, e, rd);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_err", {31'd0, e}, 32'd0);
    chk("post_rst_rdata", rd, 32'hDEAD_BEEF);

    // Back-to-back SB then LHU, second start in the first IDLE cycle
    mem[0] <= 32'd0;
    @(negedge clk_i);
    w0 = wr_cnt;
    run_cmd(1'b0, 1'b1, 3'b000, 32'h1, 32'h0000_00AA, 0, 0, lat, e, rd);
    chk("b2b_sb_lat", lat, 3);
    chk("b2b_sb_err", {31'd0, e}, 32'd0);
    run_cmd(1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 0, 0, lat, e, rd);
    chk("b2b_sb_wword", last_wword, 32'h0000_AA00);
    chk("b2b_sb_wrs", wr_cnt - w0, 1);
    chk("b2b_lhu_lat", lat, 2);
    chk("b2b_lhu_rdata", rd, 32'h0000_AA00);
    @(negedge clk_i);
    chk("b2b_final_idle", {31'd0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
